// File: rtl/hack_kbd_pkg.sv
// Shared constants for the Hack keyboard controller: key codes and default sizes.
package hack_kbd_pkg;

  localparam int unsigned KBD_WIDTH = 16;
  localparam int unsigned KBD_DEPTH = 8;

  localparam logic [15:0] KEY_NONE  = 16'd0;
  localparam logic [15:0] NEWLINE   = 16'd128;
  localparam logic [15:0] BACKSPACE = 16'd129;
  localparam logic [15:0] LEFT      = 16'd130;
  localparam logic [15:0] UP        = 16'd131;
  localparam logic [15:0] RIGHT     = 16'd132;
  localparam logic [15:0] DOWN      = 16'd133;
  localparam logic [15:0] ESC       = 16'd140;

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous show-ahead FIFO; a push while full succeeds only when a pop happens in the same
// cycle. Head reads as 0 when empty.
module kbd_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/hack_kbd_ctrl.sv
// Hack keyboard controller: held-key register plus a key-press event FIFO with sticky overflow.
// Define KBD_REPEAT_EN to build typematic auto-repeat.
module hack_kbd_ctrl
  import hack_kbd_pkg::*;
#(
  parameter int unsigned WIDTH        = KBD_WIDTH,
  parameter int unsigned DEPTH        = KBD_DEPTH,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 50
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_valid,
  input  logic [WIDTH-1:0]       key_code,
  input  logic                   key_release,
  output logic                   key_ready,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       out,
  output logic [WIDTH-1:0]       fifo_data,
  output logic                   fifo_empty,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("hack_kbd_ctrl: DEPTH must be a power of two and at least 2");
  end
  if (REPEAT_RATE < 1 || REPEAT_DELAY < 1) begin : g_bad_repeat
    $error("hack_kbd_ctrl: REPEAT_DELAY and REPEAT_RATE must be at least 1");
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             press, release_hit, rep_push, push_req, fifo_full, fifo_pop;

  assign press       = key_valid && !key_release && (key_code != WIDTH'(KEY_NONE));
  assign release_hit = key_valid && key_release && (key_code != WIDTH'(KEY_NONE)) &&
                       (key_code == out_q);
  assign push_req    = press || rep_push;
  assign fifo_pop    = rd_en && !fifo_empty;
  assign key_ready   = !reset;
  assign out         = out_q;
  assign overflow    = ovf_q;

  always_comb begin
    out_d = out_q;
    if (press) begin
      out_d = key_code;
    end else if (release_hit) begin
      out_d = '0;
    end
  end

  // Set beats clear when both happen in one cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (push_req && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end else if (clr_overflow) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef KBD_REPEAT_EN
  logic [31:0] rep_cnt_q, rep_cnt_d;
  logic        rep_first_q, rep_first_d;

  // rep_first selects the initial delay; afterwards the shorter rate applies.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_push    = 1'b0;
    if (press || release_hit || (out_q == '0)) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if ((rep_cnt_q + 32'd1) == (rep_first_q ? 32'(REPEAT_DELAY) : 32'(REPEAT_RATE))) begin
      rep_push    = 1'b1;
      rep_cnt_d   = '0;
      rep_first_d = 1'b0;
    end else begin
      rep_cnt_d = rep_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_push = 1'b0;
`endif

  kbd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (rd_en),
    .wdata (out_d),
    .rdata (fifo_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: doc/hack_kbd_ctrl.md
Name: hack_kbd_ctrl

Overview:
Parametrised Hack keyboard controller. It replaces the fixed single-register keyboard.
- Keeps Hack semantics: `out` holds the code of the currently pressed key, and 0 when no key is pressed.
- Adds a buffered key-press event queue that the CPU can pop, a sticky overflow flag, and optional typematic auto-repeat.
- Sits between the host-side key source and the memory map at the KBD address (`out`), with the queue at adjacent registers.

Parameters:
- WIDTH, 16, key code / data width in bits.
- DEPTH, 8, event FIFO entries; power of two, minimum 2.
- REPEAT_DELAY, 500, cycles a key is held before the first auto-repeat; used only with the macro.
- REPEAT_RATE, 50, cycles between subsequent repeats; used only with the macro; minimum 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- key_valid  in  1  a key event is presented this cycle.
- key_code  in  WIDTH  Hack key code of the event.
- key_release  in  1  1 = release event, 0 = press event; qualified by key_valid.
- key_ready  out  1  always 1 outside reset; events are never back-pressured.
- rd_en  in  1  CPU pop strobe for the event FIFO.
- out  out  WIDTH  currently held key code; 0 = none.
- fifo_data  out  WIDTH  head of the FIFO (show-ahead); 0 when empty.
- fifo_empty  out  1  FIFO has no entries.
- fifo_count  out  $clog2(DEPTH)+1  number of valid entries.
- overflow  out  1  sticky: a press was dropped because the FIFO was full.
- clr_overflow  in  1  clears `overflow`.

Behaviour:
- Reset (synchronous, active-high, dominant over every input):
  - `out`=0, FIFO pointers and `fifo_count`=0, `fifo_empty`=1, `fifo_data`=0, `overflow`=0, `key_ready`=0, repeat counter=0.
  - A reset asserted mid-operation discards all queued events.
- Press event (key_valid=1, key_release=0, key_code≠0):
  - `out` takes key_code one cycle later; a new press overrides any held key.
  - The code is pushed into the FIFO in the same edge.
- Release event (key_valid=1, key_release=1):
  - If key_code equals `out`, `out` becomes 0 the next cycle.
  - Otherwise the event is ignored.
  - Releases are never queued.
- key_code=0 with key_valid=1: ignored entirely (no `out` change, no push).
- Push when full:
  - Without a same-cycle pop, the event is dropped and `overflow` is set the next cycle.
  - With a same-cycle pop, the pop is performed first, the push succeeds, and no overflow is flagged.
- Pop: rd_en=1 and not empty advances the head; `fifo_data` shows the new head the next cycle. rd_en while empty is ignored.
- Simultaneous push and pop when non-empty: `fifo_count` is unchanged.
- Simultaneous push into an empty FIFO: the entry becomes visible on `fifo_data` the next cycle (no fall-through).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; `fifo_count` saturates at DEPTH.
- Overflow: clr_overflow clears the flag; if an overflow event occurs in the same cycle, set wins.
- Latency: input event to `out` / `fifo_count` update is 1 cycle.

Optional Feature:
- Macro: KBD_REPEAT_EN.
- Defined:
  - A repeat counter runs while `out`≠0.
  - After REPEAT_DELAY cycles of a steady `out`, `out` is re-pushed into the FIFO, then again every REPEAT_RATE cycles.
  - A repeat push follows the same full / overflow rules as a press.
  - The counter restarts on any press, on a release that clears `out`, and on reset.
  - A repeat push coinciding with an external press is suppressed; the press wins.
- Undefined: no counter logic is built; REPEAT_DELAY and REPEAT_RATE are unused.

Decomposition:
- Package hack_kbd_pkg holds:
  - KEY_NONE=0.
  - Hack special key codes: NEWLINE=128, BACKSPACE=129, LEFT=130, UP=131, RIGHT=132, DOWN=133, ESC=140.
  - Default WIDTH/DEPTH constants.
- Sub-module kbd_fifo: synchronous show-ahead FIFO (WIDTH, DEPTH) with push, pop, full, empty, count. It is instantiated once; the top level holds `out`, the overflow flag and the repeat logic.

Test Plan:
- Reset, then press 0x0041 → `out`=0x0041 after 1 cycle; `fifo_data`=0x0041; `fifo_count`=1. Release 0x0041 → `out`=0; `fifo_count` still 1.
- Press 0x0041 then press 0x0042 without a release; release 0x0041 → `out` stays 0x0042. Release 0x0042 → `out`=0.
- With DEPTH=8, push 9 distinct presses with no pops → `fifo_count`=8, `overflow`=1, 9th code absent. Pop 8 times → codes in order, then `fifo_empty`=1. clr_overflow → `overflow`=0.
- FIFO full and press coincident with rd_en → `fifo_count` stays 8, `overflow`=0, the new code is at the tail.
- Reset asserted with 3 entries queued and `out`=0x0080 → next cycle `out`=0, `fifo_count`=0, `fifo_empty`=1.
- KBD_REPEAT_EN with REPEAT_DELAY=10, REPEAT_RATE=4: hold 0x0041 for 20 cycles → pushes at the press edge and at +10, +14 and +18 cycles (`fifo_count`=4). Release stops further pushes.
